// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
// Optional feature macro used by the arbiter: WB_STARVE_EN.
package regfile_wb_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_ADDR_W     = 5;
  localparam int WB_NREGS      = 32;
  localparam int WB_STARVE_MAX = 4;

  // Occupancy of the one-entry mult/div result buffer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // buffer empty
    HELD  = 2'd1,  // buffer full, waiting for a free write slot
    FORCE = 2'd2   // buffer full, ALU blocked so the buffer drains now
  } wb_state_t;

  // Which source owns the write port in the current cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    ALU  = 2'd1,
    MD   = 2'd2,
    BUF  = 2'd3
  } wb_src_t;

endpackage

// File: rtl/wb_addr_decode.sv
// Register address to one-hot write-enable decoder. The strobe gates every
// output bit, and bit 0 is tied low because r0 is hard-wired to zero.
module wb_addr_decode
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int NREGS  = WB_NREGS
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              strobe,
  output logic [NREGS-1:0]  onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi = gi + 1) begin : g_dec
      if (gi == 0) begin : g_r0
        // r0 is never written
        assign onehot[gi] = 1'b0;
      end else begin : g_rn
        // one comparator per register
        assign onehot[gi] = strobe && (addr == ADDR_W'(gi));
      end
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter between the ALU writeback stage and the
// multicycle mult/div unit. One mult/div result can be parked in a buffer
// while the ALU owns the port; a same-register ALU write kills it (WAW).
// Macro WB_STARVE_EN: adds a starvation counter that forces the buffered
// result out after STARVE_MAX consecutive ALU wins. Without it the ALU has
// strict priority and the buffer drains only in an ALU-idle cycle.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int NREGS      = WB_NREGS,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic [NREGS-1:0]  wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              md_pending,
  output logic [ADDR_W-1:0] md_pending_rd
);

  wb_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] buf_rd_reg, buf_rd_next;
  logic [DATA_W-1:0] buf_data_reg, buf_data_next;

  wb_src_t           src;
  logic              sel_strobe;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREGS-1:0]  dec_onehot;

  logic [NREGS-1:0]  wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  logic              idle_waw;
  logic              alu_kills_buf;

  // An ALU write to the same nonzero register supersedes an older md result.
  assign idle_waw      = (md_rd == alu_rd) && (alu_rd != '0);
  assign alu_kills_buf = (buf_rd_reg == alu_rd) && (alu_rd != '0);

  assign md_ready = !clr && (state_reg == IDLE);

`ifdef WB_STARVE_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next, starve_cnt_inc;

  assign starve_cnt_inc = starve_cnt_reg + CNT_W'(1);
  assign alu_ready      = !clr && (state_reg != FORCE);
`else
  // STARVE_MAX only matters when the starvation guard is built in.
  logic unused_starve;
  assign unused_starve = (STARVE_MAX > 0);
  assign alu_ready     = !clr;
`endif

  // Next-state, buffer update and write-source selection.
  always_comb begin
    state_next    = state_reg;
    buf_rd_next   = buf_rd_reg;
    buf_data_next = buf_data_reg;
    src           = NONE;
`ifdef WB_STARVE_EN
    starve_cnt_next = starve_cnt_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (alu_valid) begin
          src = ALU;
          // Park the colliding md result unless the ALU write makes it dead.
          if (md_valid && !idle_waw) begin
            buf_rd_next   = md_rd;
            buf_data_next = md_data;
            state_next    = HELD;
`ifdef WB_STARVE_EN
            starve_cnt_next = '0;
`endif
          end
        end else if (md_valid) begin
          src = MD;
        end
      end
      HELD: begin
        if (!alu_valid) begin
          src        = BUF;
          state_next = IDLE;
        end else if (alu_kills_buf) begin
          src        = ALU;
          state_next = IDLE;
`ifdef WB_STARVE_EN
          starve_cnt_next = '0;
`endif
        end else begin
          src = ALU;
`ifdef WB_STARVE_EN
          starve_cnt_next = starve_cnt_inc;
          if (starve_cnt_inc == CNT_W'(STARVE_MAX)) begin
            state_next = FORCE;
          end
`endif
        end
      end
`ifdef WB_STARVE_EN
      FORCE: begin
        src             = BUF;
        state_next      = IDLE;
        starve_cnt_next = '0;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write-port mux driven by the selected source.
  always_comb begin
    sel_strobe = (src != NONE);
    sel_addr   = wr_addr_reg;
    sel_data   = wr_data_reg;
    unique case (src)
      ALU: begin
        sel_addr = alu_rd;
        sel_data = alu_data;
      end
      MD: begin
        sel_addr = md_rd;
        sel_data = md_data;
      end
      BUF: begin
        sel_addr = buf_rd_reg;
        sel_data = buf_data_reg;
      end
      default: begin
        sel_addr = wr_addr_reg;
        sel_data = wr_data_reg;
      end
    endcase
  end

  wb_addr_decode #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_wr_dec (
    .addr   (sel_addr),
    .strobe (sel_strobe),
    .onehot (dec_onehot)
  );

  // Arbitration state and buffer registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= IDLE;
      buf_rd_reg   <= '0;
      buf_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      buf_rd_reg   <= buf_rd_next;
      buf_data_reg <= buf_data_next;
    end
  end

`ifdef WB_STARVE_EN
  // Count consecutive ALU wins while a result waits in the buffer.
  always_ff @(posedge clk) begin
    if (clr) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`endif

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_en_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= dec_onehot;
      if (sel_strobe) begin
        wr_addr_reg <= sel_addr;
        wr_data_reg <= sel_data;
      end
    end
  end

  assign wr_en         = wr_en_reg;
  assign wr_addr       = wr_addr_reg;
  assign wr_data       = wr_data_reg;
  assign md_pending    = (state_reg != IDLE);
  assign md_pending_rd = md_pending ? buf_rd_reg : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, hand-written
// starvation sequence, then randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int SMAX = 4;
`ifdef WB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk;
  logic          clr;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          md_valid;
  logic [AW-1:0] md_rd;
  logic [DW-1:0] md_data;
  logic          md_ready;
  logic [NR-1:0] wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          md_pending;
  logic [AW-1:0] md_pending_rd;

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .clr(clr),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .md_pending(md_pending), .md_pending_rd(md_pending_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] adata;
    logic          mv;
    logic [AW-1:0] mrd;
    logic [DW-1:0] mdata;
  } in_t;

  typedef struct {
    in_t           in;
    logic          e_ar;
    logic          e_mr;
    logic [NR-1:0] e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_pend;
    logic [AW-1:0] e_prd;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(int c, int av, int ard, int adata, int mv, int mrd, int mdata,
                              int ear, int emr, int een, int eaddr, int edata, int epend, int eprd);
    vec_t v;
    v.in.clr   = (c != 0);
    v.in.av    = (av != 0);
    v.in.ard   = AW'(ard);
    v.in.adata = DW'(adata);
    v.in.mv    = (mv != 0);
    v.in.mrd   = AW'(mrd);
    v.in.mdata = DW'(mdata);
    v.e_ar     = (ear != 0);
    v.e_mr     = (emr != 0);
    v.e_en     = NR'(een);
    v.e_addr   = AW'(eaddr);
    v.e_data   = DW'(edata);
    v.e_pend   = (epend != 0);
    v.e_prd    = AW'(eprd);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, check readies mid-cycle, outputs after the edge.
  task automatic run_vec(input string tag, input int idx, input vec_t v);
    clr       = v.in.clr;
    alu_valid = v.in.av;
    alu_rd    = v.in.ard;
    alu_data  = v.in.adata;
    md_valid  = v.in.mv;
    md_rd     = v.in.mrd;
    md_data   = v.in.mdata;
    #1;
    cmp({tag, "_alu_ready"}, 64'(alu_ready), 64'(v.e_ar));
    cmp({tag, "_md_ready"},  64'(md_ready),  64'(v.e_mr));
    @(posedge clk);
    #1;
    cmp({tag, "_wr_en"},         64'(wr_en),         64'(v.e_en));
    cmp({tag, "_wr_addr"},       64'(wr_addr),       64'(v.e_addr));
    cmp({tag, "_wr_data"},       64'(wr_data),       64'(v.e_data));
    cmp({tag, "_md_pending"},    64'(md_pending),    64'(v.e_pend));
    cmp({tag, "_md_pending_rd"}, 64'(md_pending_rd), 64'(v.e_prd));
    $display("%s %0d clr=%0d alu=%0d rd%0d %0h md=%0d rd%0d %0h -> wr_en=%0h addr=%0d data=%0h pend=%0d/%0d",
             tag, idx, v.in.clr, v.in.av, v.in.ard, v.in.adata, v.in.mv, v.in.mrd, v.in.mdata,
             wr_en, wr_addr, wr_data, md_pending, md_pending_rd);
  endtask

  // Reference model: the pending result as a plain record plus a win count.
  bit            m_pend;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int            m_wins;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dat;

  function automatic vec_t model_step(input in_t x);
    vec_t v;
    bit            forcing;
    bit            wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    v.in    = x;
    forcing = STARVE_ON && m_pend && (m_wins >= SMAX);
    v.e_ar  = !x.clr && !forcing;
    v.e_mr  = !x.clr && !m_pend;
    wr = 1'b0;
    wa = '0;
    wd = '0;
    if (x.clr) begin
      m_pend = 1'b0; m_rd = '0; m_data = '0; m_wins = 0; m_addr = '0; m_dat = '0;
    end else if (forcing || (m_pend && !x.av)) begin
      wr = 1'b1; wa = m_rd; wd = m_data;
      m_pend = 1'b0; m_wins = 0;
    end else if (m_pend) begin
      wr = 1'b1; wa = x.ard; wd = x.adata;
      if (x.ard == m_rd && x.ard != 0) begin
        m_pend = 1'b0; m_wins = 0;
      end else begin
        m_wins = m_wins + 1;
      end
    end else if (x.av) begin
      wr = 1'b1; wa = x.ard; wd = x.adata;
      if (x.mv && !(x.mrd == x.ard && x.ard != 0)) begin
        m_pend = 1'b1; m_rd = x.mrd; m_data = x.mdata; m_wins = 0;
      end
    end else if (x.mv) begin
      wr = 1'b1; wa = x.mrd; wd = x.mdata;
    end
    if (wr) begin
      m_addr = wa;
      m_dat  = wd;
    end
    v.e_en   = (wr && wa != 0) ? (NR'(1) << wa) : '0;
    v.e_addr = m_addr;
    v.e_data = m_dat;
    v.e_pend = m_pend;
    v.e_prd  = m_pend ? m_rd : '0;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    vec_t v;
    in_t  x;
    int   av_pct;

    clr = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;

    //            clr av rd dat    mv rd dat    ar mr en           addr data    pend prd
    tbl[0]  = mk(1, 1, 3, 'h55,   1, 4, 'h66,  0, 0, 0,           0,  0,       0, 0);
    tbl[1]  = mk(0, 1, 3, 'h11,   0, 0, 0,     1, 1, 'h8,         3,  'h11,    0, 0);
    tbl[2]  = mk(0, 1, 4, 'hA,    1, 5, 'hB,   1, 1, 'h10,        4,  'hA,     1, 5);
    tbl[3]  = mk(0, 0, 0, 0,      0, 0, 0,     1, 0, 'h20,        5,  'hB,     0, 0);
    tbl[4]  = mk(0, 0, 0, 0,      0, 0, 0,     1, 1, 0,           5,  'hB,     0, 0);
    tbl[5]  = mk(0, 1, 7, 'h70,   1, 7, 'h77,  1, 1, 'h80,        7,  'h70,    0, 0);
    tbl[6]  = mk(0, 0, 0, 0,      0, 0, 0,     1, 1, 0,           7,  'h70,    0, 0);
    tbl[7]  = mk(0, 1, 8, 'h80,   1, 7, 'h71,  1, 1, 'h100,       8,  'h80,    1, 7);
    tbl[8]  = mk(0, 1, 7, 'h72,   0, 0, 0,     1, 0, 'h80,        7,  'h72,    0, 0);
    tbl[9]  = mk(0, 0, 0, 0,      0, 0, 0,     1, 1, 0,           7,  'h72,    0, 0);
    tbl[10] = mk(0, 0, 0, 0,      1, 0, 'hFF,  1, 1, 0,           0,  'hFF,    0, 0);
    tbl[11] = mk(0, 1, 0, 'h12,   1, 0, 'h34,  1, 1, 0,           0,  'h12,    1, 0);
    tbl[12] = mk(0, 0, 0, 0,      0, 0, 0,     1, 0, 0,           0,  'h34,    0, 0);
    tbl[13] = mk(0, 1, 9, 'h99,   1, 10, 'hAA, 1, 1, 'h200,       9,  'h99,    1, 10);
    tbl[14] = mk(1, 1, 11, 'hBB,  0, 0, 0,     0, 0, 0,           0,  0,       0, 0);
    tbl[15] = mk(0, 0, 0, 0,      0, 0, 0,     1, 1, 0,           0,  0,       0, 0);
    tbl[16] = mk(0, 0, 0, 0,      1, 31, 'hDEAD, 1, 1, 'h80000000, 31, 'hDEAD, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      run_vec("vec", i, tbl[i]);
    end

    // Held md result for r5 while the ALU keeps writing r6.
    run_vec("starve", 0, mk(0, 1, 6, 'h600, 1, 5, 'hB5, 1, 1, 'h40, 6, 'h600, 1, 5));
`ifdef WB_STARVE_EN
    for (int i = 1; i <= SMAX; i++) begin
      run_vec("starve", i, mk(0, 1, 6, 'h600 + i, 0, 0, 0, 1, 0, 'h40, 6, 'h600 + i, 1, 5));
    end
    run_vec("starve", SMAX + 1, mk(0, 1, 6, 'h6FF, 0, 0, 0, 0, 0, 'h20, 5, 'hB5, 0, 0));
    run_vec("starve", SMAX + 2, mk(0, 1, 6, 'h606, 0, 0, 0, 1, 1, 'h40, 6, 'h606, 0, 0));
`else
    for (int i = 1; i <= 10; i++) begin
      run_vec("starve", i, mk(0, 1, 6, 'h600 + i, 0, 0, 0, 1, 0, 'h40, 6, 'h600 + i, 1, 5));
    end
    run_vec("starve", 11, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h20, 5, 'hB5, 0, 0));
    run_vec("starve", 12, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 'hB5, 0, 0));
`endif

    // Randomized traffic; the first cycle resets so the model starts in sync.
    for (int i = 0; i < 400; i++) begin
      av_pct  = ((i / 50) % 2 == 1) ? 95 : 55;
      x.clr   = (i == 0) || ($urandom_range(0, 59) == 0);
      x.av    = ($urandom_range(0, 99) < av_pct);
      x.ard   = AW'($urandom_range(0, 7));
      x.adata = $urandom;
      x.mv    = ($urandom_range(0, 99) < 50);
      x.mrd   = AW'($urandom_range(0, 7));
      x.mdata = $urandom;
      v = model_step(x);
      run_vec("rand", i, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
